// File: rtl/zxesp32_bridge.sv
// ESP32 co-processor bridge: registered UART TX, synchronised UART RX and GPIO with edge detect,
// plus a boot sequencer that pulses EN and drives the GPIO0 strap for normal/bootloader entry.
module zxesp32_bridge #(
    parameter int GPIO_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 1000,
    parameter int HOLD_CYCLES  = 2000
) (
    input  logic                  clk_peripheral,
    input  logic                  reset,
    input  logic                  uart_tx_i,
    output logic                  uart_rx_i,
    output logic                  uart_tx_o,
    input  logic                  uart_rx_o,
    input  logic [GPIO_WIDTH-1:0] gpio_out,
    input  logic [GPIO_WIDTH-1:0] gpio_enable,
    output logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_rise,
    output logic [GPIO_WIDTH-1:0] gpio_fall,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_t,
    output logic                  esp_en_o,
    input  logic                  boot_req,
    input  logic                  boot_mode,
    output logic                  boot_busy
);

    localparam int MAX_CYC = (RESET_CYCLES > HOLD_CYCLES) ? RESET_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int WARM_W  = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST,
        ST_STRAP
    } state_t;

    logic                                   uart_tx_q, uart_tx_d;
    logic [SYNC_STAGES-1:0]                 rx_sync_q, rx_sync_d;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] gpio_sync_q, gpio_sync_d;
    logic [GPIO_WIDTH-1:0]                  gpio_prev_q, gpio_prev_d;
    logic [GPIO_WIDTH-1:0]                  gpio_rise_q, gpio_rise_d;
    logic [GPIO_WIDTH-1:0]                  gpio_fall_q, gpio_fall_d;
    logic [GPIO_WIDTH-1:0]                  gpio_o_q, gpio_o_d;
    logic [GPIO_WIDTH-1:0]                  gpio_t_q, gpio_t_d;
    logic [WARM_W-1:0]                      warm_q, warm_d;
    logic [GPIO_WIDTH-1:0]                  gpio_sync_out;
    logic [GPIO_WIDTH-1:0]                  gpio_o_mux, gpio_t_mux;

    state_t           state_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             esp_en_q;
    logic             busy_q;

    assign gpio_sync_out = gpio_sync_q[SYNC_STAGES-1];

    always_comb begin
        uart_tx_d   = uart_tx_i;
        rx_sync_d   = {rx_sync_q[SYNC_STAGES-2:0], uart_rx_o};
        gpio_sync_d = gpio_sync_q;
        gpio_sync_d[0] = gpio_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            gpio_sync_d[i] = gpio_sync_q[i-1];
        end
        gpio_prev_d = gpio_sync_out;
        gpio_o_d    = gpio_out;
        gpio_t_d    = ~gpio_enable;
        warm_d      = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);
        gpio_rise_d = '0;
        gpio_fall_d = '0;
        // Edges are masked until the sync chain has flushed its reset value.
        if (warm_q == WARM_DONE) begin
            gpio_rise_d = gpio_sync_out & ~gpio_prev_q;
            gpio_fall_d = ~gpio_sync_out & gpio_prev_q;
        end
    end

    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) begin
            uart_tx_q   <= 1'b1;
            rx_sync_q   <= '1;
            gpio_sync_q <= '0;
            gpio_prev_q <= '0;
            gpio_rise_q <= '0;
            gpio_fall_q <= '0;
            gpio_o_q    <= '0;
            gpio_t_q    <= '1;
            warm_q      <= '0;
        end else begin
            uart_tx_q   <= uart_tx_d;
            rx_sync_q   <= rx_sync_d;
            gpio_sync_q <= gpio_sync_d;
            gpio_prev_q <= gpio_prev_d;
            gpio_rise_q <= gpio_rise_d;
            gpio_fall_q <= gpio_fall_d;
            gpio_o_q    <= gpio_o_d;
            gpio_t_q    <= gpio_t_d;
            warm_q      <= warm_d;
        end
    end

    // Requests are only honoured in IDLE; anything arriving while busy is dropped.
    always_ff @(posedge clk_peripheral or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RST;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            esp_en_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    esp_en_q <= 1'b1;
                    busy_q   <= 1'b0;
                    if (boot_req) begin
                        mode_q   <= boot_mode;
                        cnt_q    <= '0;
                        state_q  <= ST_RST;
                        esp_en_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RST: begin
                    esp_en_q <= 1'b0;
                    if (cnt_q == RST_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= ST_STRAP;
                        esp_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STRAP: begin
                    esp_en_q <= 1'b1;
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_RST;
                    mode_q   <= 1'b0;
                    cnt_q    <= '0;
                    esp_en_q <= 1'b0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    // Strap override selects between registered values only, so pin outputs stay glitch-free.
    always_comb begin
        gpio_o_mux = gpio_o_q;
        gpio_t_mux = gpio_t_q;
        if (busy_q) begin
            gpio_o_mux[0] = 1'b0;
            gpio_t_mux[0] = ~mode_q;
        end
    end

    assign uart_tx_o = uart_tx_q;
    assign uart_rx_i = rx_sync_q[SYNC_STAGES-1];
    assign gpio_in   = gpio_sync_out;
    assign gpio_rise = gpio_rise_q;
    assign gpio_fall = gpio_fall_q;
    assign gpio_o    = gpio_o_mux;
    assign gpio_t    = gpio_t_mux;
    assign esp_en_o  = esp_en_q;
    assign boot_busy = busy_q;

endmodule

// File: tb/tb_zxesp32_bridge.sv
// Directed bench for zxesp32_bridge with short boot timings (RESET_CYCLES=4, HOLD_CYCLES=6).
module tb_zxesp32_bridge;

    localparam int W = 3;
    localparam int S = 2;
    localparam int R = 4;
    localparam int H = 6;

    logic         clk_peripheral = 1'b0;
    logic         reset = 1'b1;
    logic         uart_tx_i, uart_rx_o;
    logic         uart_rx_i, uart_tx_o;
    logic [W-1:0] gpio_out, gpio_enable, gpio_i;
    logic [W-1:0] gpio_in, gpio_rise, gpio_fall, gpio_o, gpio_t;
    logic         esp_en_o, boot_req, boot_mode, boot_busy;

    int errors = 0;
    int checks = 0;

    zxesp32_bridge #(
        .GPIO_WIDTH(W), .SYNC_STAGES(S), .RESET_CYCLES(R), .HOLD_CYCLES(H)
    ) dut (
        .clk_peripheral(clk_peripheral), .reset(reset),
        .uart_tx_i(uart_tx_i), .uart_rx_i(uart_rx_i),
        .uart_tx_o(uart_tx_o), .uart_rx_o(uart_rx_o),
        .gpio_out(gpio_out), .gpio_enable(gpio_enable),
        .gpio_in(gpio_in), .gpio_rise(gpio_rise), .gpio_fall(gpio_fall),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t),
        .esp_en_o(esp_en_o), .boot_req(boot_req), .boot_mode(boot_mode),
        .boot_busy(boot_busy)
    );

    always #5 clk_peripheral = ~clk_peripheral;

    task automatic step();
        @(posedge clk_peripheral);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_in;
        reset = 1'b1; gpio_i = 3'b111; uart_rx_o = 1'b1; uart_tx_i = 1'b1;
        gpio_out = '0; gpio_enable = '0; boot_req = 1'b0; boot_mode = 1'b0;
        step(); step();
        checks++; if (esp_en_o !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", esp_en_o); end
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", boot_busy); end
        checks++; if (gpio_t !== 3'b111) begin errors++; $display("FAIL rst_gpio_t: got %b want 111", gpio_t); end
        checks++; if (gpio_o !== 3'b000) begin errors++; $display("FAIL rst_gpio_o: got %b want 000", gpio_o); end
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", uart_tx_o); end
        checks++; if (uart_rx_i !== 1'b1) begin errors++; $display("FAIL rst_rx: got %b want 1", uart_rx_i); end
        checks++; if (gpio_in !== 3'b000) begin errors++; $display("FAIL rst_gpio_in: got %b want 000", gpio_in); end
        reset = 1'b0;
        for (int c = 1; c <= R + H + 1; c++) begin
            step();
            exp_in = (c >= S) ? 3'b111 : 3'b000;
            checks++; if (esp_en_o !== (c >= R)) begin errors++; $display("FAIL pwr_en c=%0d: got %b want %b", c, esp_en_o, (c >= R)); end
            checks++; if (boot_busy !== (c < R + H)) begin errors++; $display("FAIL pwr_busy c=%0d: got %b want %b", c, boot_busy, (c < R + H)); end
            checks++; if (gpio_t !== 3'b111) begin errors++; $display("FAIL pwr_gpio_t c=%0d: got %b want 111", c, gpio_t); end
            checks++; if (gpio_in !== exp_in) begin errors++; $display("FAIL pwr_gpio_in c=%0d: got %b want %b", c, gpio_in, exp_in); end
            checks++; if (gpio_rise !== 3'b000) begin errors++; $display("FAIL warm_rise c=%0d: got %b want 000", c, gpio_rise); end
            checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL pwr_tx c=%0d: got %b want 1", c, uart_tx_o); end
        end
    endtask

    task automatic test_boot_bootloader();
        logic exp_busy;
        logic [W-1:0] exp_t, exp_o;
        gpio_enable = 3'b110; gpio_out = 3'b111;
        step(); step();
        checks++; if (gpio_t !== 3'b001) begin errors++; $display("FAIL core_t: got %b want 001", gpio_t); end
        checks++; if (gpio_o !== 3'b111) begin errors++; $display("FAIL core_o: got %b want 111", gpio_o); end
        boot_req = 1'b1; boot_mode = 1'b1;
        step();
        boot_req = 1'b0; boot_mode = 1'b0;
        for (int c = 0; c <= R + H; c++) begin
            if (c > 0) step();
            exp_busy = (c < R + H);
            exp_t = exp_busy ? 3'b000 : 3'b001;
            exp_o = exp_busy ? 3'b110 : 3'b111;
            checks++; if (esp_en_o !== (c >= R)) begin errors++; $display("FAIL bl_en c=%0d: got %b want %b", c, esp_en_o, (c >= R)); end
            checks++; if (boot_busy !== exp_busy) begin errors++; $display("FAIL bl_busy c=%0d: got %b want %b", c, boot_busy, exp_busy); end
            checks++; if (gpio_t !== exp_t) begin errors++; $display("FAIL bl_gpio_t c=%0d: got %b want %b", c, gpio_t, exp_t); end
            checks++; if (gpio_o !== exp_o) begin errors++; $display("FAIL bl_gpio_o c=%0d: got %b want %b", c, gpio_o, exp_o); end
        end
    endtask

    task automatic test_busy_request();
        boot_req = 1'b1; boot_mode = 1'b0;
        step();
        boot_req = 1'b0;
        for (int c = 0; c <= R + H + 5; c++) begin
            if (c > 0) step();
            checks++; if (boot_busy !== (c < R + H)) begin errors++; $display("FAIL busy_req_busy c=%0d: got %b want %b", c, boot_busy, (c < R + H)); end
            checks++; if (esp_en_o !== (c >= R)) begin errors++; $display("FAIL busy_req_en c=%0d: got %b want %b", c, esp_en_o, (c >= R)); end
            checks++; if (gpio_t !== 3'b001) begin errors++; $display("FAIL busy_req_t c=%0d: got %b want 001", c, gpio_t); end
            if (c == 2) begin boot_req = 1'b1; boot_mode = 1'b1; end
            if (c == 3) begin boot_req = 1'b0; boot_mode = 1'b0; end
            if (c == R + H - 1) boot_req = 1'b1;
            if (c == R + H) boot_req = 1'b0;
        end
    endtask

    task automatic test_gpio_edges();
        logic [W-1:0] exp_in, exp_edge;
        gpio_i = 3'b011;
        repeat (6) step();
        gpio_i = 3'b111;
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_in = (c >= S) ? 3'b111 : 3'b011;
            exp_edge = (c == S + 1) ? 3'b100 : 3'b000;
            checks++; if (gpio_in !== exp_in) begin errors++; $display("FAIL rise_in c=%0d: got %b want %b", c, gpio_in, exp_in); end
            checks++; if (gpio_rise !== exp_edge) begin errors++; $display("FAIL rise_pulse c=%0d: got %b want %b", c, gpio_rise, exp_edge); end
            checks++; if (gpio_fall !== 3'b000) begin errors++; $display("FAIL rise_nofall c=%0d: got %b want 000", c, gpio_fall); end
        end
        gpio_i = 3'b011;
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_in = (c >= S) ? 3'b011 : 3'b111;
            exp_edge = (c == S + 1) ? 3'b100 : 3'b000;
            checks++; if (gpio_in !== exp_in) begin errors++; $display("FAIL fall_in c=%0d: got %b want %b", c, gpio_in, exp_in); end
            checks++; if (gpio_fall !== exp_edge) begin errors++; $display("FAIL fall_pulse c=%0d: got %b want %b", c, gpio_fall, exp_edge); end
            checks++; if (gpio_rise !== 3'b000) begin errors++; $display("FAIL fall_norise c=%0d: got %b want 000", c, gpio_rise); end
        end
    endtask

    task automatic test_uart();
        uart_tx_i = 1'b0; uart_rx_o = 1'b0;
        step();
        checks++; if (uart_tx_o !== 1'b0) begin errors++; $display("FAIL tx_lat1: got %b want 0", uart_tx_o); end
        checks++; if (uart_rx_i !== 1'b1) begin errors++; $display("FAIL rx_lat1: got %b want 1", uart_rx_i); end
        step();
        checks++; if (uart_rx_i !== 1'b0) begin errors++; $display("FAIL rx_lat2: got %b want 0", uart_rx_i); end
        uart_tx_i = 1'b1; uart_rx_o = 1'b1;
        step();
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL tx_back: got %b want 1", uart_tx_o); end
        checks++; if (uart_rx_i !== 1'b0) begin errors++; $display("FAIL rx_hold: got %b want 0", uart_rx_i); end
        step();
        checks++; if (uart_rx_i !== 1'b1) begin errors++; $display("FAIL rx_back: got %b want 1", uart_rx_i); end
    endtask

    task automatic test_reset_mid_boot();
        boot_req = 1'b1; boot_mode = 1'b1;
        step();
        boot_req = 1'b0; boot_mode = 1'b0;
        step(); step();
        checks++; if (gpio_t[0] !== 1'b0) begin errors++; $display("FAIL mid_strap: got %b want 0", gpio_t[0]); end
        #1 reset = 1'b1;
        #1;
        checks++; if (esp_en_o !== 1'b0) begin errors++; $display("FAIL abort_en: got %b want 0", esp_en_o); end
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", boot_busy); end
        checks++; if (gpio_t !== 3'b111) begin errors++; $display("FAIL abort_t: got %b want 111", gpio_t); end
        checks++; if (gpio_in !== 3'b000) begin errors++; $display("FAIL abort_in: got %b want 000", gpio_in); end
        step();
        reset = 1'b0;
        for (int c = 1; c <= R + 1; c++) begin
            step();
            checks++; if (esp_en_o !== (c >= R)) begin errors++; $display("FAIL rerst_en c=%0d: got %b want %b", c, esp_en_o, (c >= R)); end
            checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL rerst_busy c=%0d: got %b want 1", c, boot_busy); end
            checks++; if (gpio_t[0] !== 1'b1) begin errors++; $display("FAIL rerst_mode c=%0d: got %b want 1", c, gpio_t[0]); end
            checks++; if (gpio_rise !== 3'b000) begin errors++; $display("FAIL rerst_warm c=%0d: got %b want 000", c, gpio_rise); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_bootloader();
        test_busy_request();
        test_gpio_edges();
        test_uart();
        test_reset_mid_boot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zxesp32_bridge.md
Name: zxesp32_bridge

Overview:
Parametrised ESP32 co-processor bridge between the ZX core's UART/GPIO peripheral and the ESP32 module pins.
- UART: registered TX; synchronised RX.
- GPIO: configurable channel count; every channel is bidirectional, synchronised and edge-detected.
- Boot sequencer: drives the ESP32 EN pin and the GPIO0 strap to reset the module into normal or bootloader mode.
- Sits between the core-side peripheral and the Xilinx GPIO tri-state pin interface.

Parameters:
GPIO_WIDTH, 3, number of GPIO channels (>=1); channel 0 is the ESP32 boot strap.
SYNC_STAGES, 2, synchroniser depth for uart_rx_o and gpio_i (>=2).
RESET_CYCLES, 1000, clk_peripheral cycles EN is held low per boot sequence (>=1).
HOLD_CYCLES, 2000, cycles the strap is held after EN release (>=1).

Ports:
clk_peripheral  in  1  sole clock.
reset  in  1  asynchronous, active-high reset.
uart_tx_i  in  1  core UART TX.
uart_rx_i  out  1  synchronised ESP32 TX to core.
uart_tx_o  out  1  registered TX to ESP32 RX pin.
uart_rx_o  in  1  ESP32 TX pin (asynchronous).
gpio_out  in  GPIO_WIDTH  core output values.
gpio_enable  in  GPIO_WIDTH  core output enables, 1 = drive.
gpio_in  out  GPIO_WIDTH  synchronised pin values to core.
gpio_rise  out  GPIO_WIDTH  one-cycle rising-edge pulse per channel.
gpio_fall  out  GPIO_WIDTH  one-cycle falling-edge pulse per channel.
gpio_i  in  GPIO_WIDTH  pin inputs (asynchronous).
gpio_o  out  GPIO_WIDTH  pin output values.
gpio_t  out  GPIO_WIDTH  pin tri-state, 1 = high-Z.
esp_en_o  out  1  ESP32 EN (chip enable), 0 = ESP32 held in reset.
boot_req  in  1  single-cycle request to start a boot sequence.
boot_mode  in  1  sampled together with boot_req: 0 = normal, 1 = bootloader.
boot_busy  out  1  high while the sequencer owns EN/GPIO0.

Behaviour:
- All registers are reset asynchronously by reset.
- UART TX:
  - uart_tx_o <= uart_tx_i; latency 1; reset value 1 (idle).
- UART RX:
  - uart_rx_o passes through a SYNC_STAGES flop chain; all stages reset to 1.
  - uart_rx_i is the last stage; latency SYNC_STAGES.
- GPIO outputs, per channel n:
  - gpio_o[n] <= gpio_out[n]; gpio_t[n] <= ~gpio_enable[n]; latency 1.
  - Reset values: gpio_o = 0, gpio_t = all 1.
  - Exception: channel 0 while boot_busy (see sequencer).
- GPIO inputs, per channel n:
  - gpio_i[n] passes through a SYNC_STAGES chain; stages reset to 0.
  - gpio_in[n] is the last stage.
  - A prev register holds the previous gpio_in value.
  - gpio_rise[n] = gpio_in & ~prev; gpio_fall[n] = ~gpio_in & prev. Both are registered and last exactly one cycle.
- Edge warm-up:
  - Edge outputs are forced to 0 for the first SYNC_STAGES+1 cycles after reset deassertion (warm-up counter).
  - This suppresses spurious edges caused by the reset values of the sync chain.
  - Reset value of all edge outputs is 0.
- Boot sequencer FSM, states IDLE, RST, STRAP:
  - Reset: state = RST, mode register = 0, counter = 0, esp_en_o = 0, boot_busy = 1. The ESP32 therefore receives a clean normal-mode reset at power-up.
  - IDLE:
    - esp_en_o = 1, boot_busy = 0.
    - boot_req = 1 latches boot_mode into the mode register, clears the counter, and moves to RST.
  - RST:
    - esp_en_o = 0.
    - When counter == RESET_CYCLES-1: clear the counter and move to STRAP.
  - STRAP:
    - esp_en_o = 1.
    - When counter == HOLD_CYCLES-1: move to IDLE.
  - Counter width: clog2(max(RESET_CYCLES, HOLD_CYCLES)).
  - boot_busy = (state != IDLE), registered together with the state.
- Channel 0 while boot_busy:
  - mode 1: gpio_t[0] = 0 and gpio_o[0] = 0 (strap driven low).
  - mode 0: gpio_t[0] = 1 (released to the board pull-up).
  - gpio_out[0]/gpio_enable[0] are ignored while busy.
  - Core values take effect on the cycle after the FSM returns to IDLE.
- boot_req while busy is ignored and not queued.
- boot_req on the same cycle as the IDLE entry is not accepted; requests are accepted only in IDLE.
- Input sync and edge detect on channel 0 keep running while busy.
- Reset asserted mid-sequence aborts immediately to the reset state (RST, mode 0).
- GPIO_WIDTH = 1 is legal: channel 0 is both a user channel and the strap.

Test Plan:
1. Reset release -> boot_busy = 1, esp_en_o = 0 for RESET_CYCLES, then 1; boot_busy falls after a further HOLD_CYCLES; gpio_t = 3'b111 throughout; uart_tx_o = 1.
2. In IDLE, pulse boot_req with boot_mode = 1 (RESET_CYCLES = 4, HOLD_CYCLES = 6) -> esp_en_o low for exactly 4 cycles; gpio_t[0] = 0 and gpio_o[0] = 0 for all 10 busy cycles; core drive restored the cycle after.
3. Second boot_req during busy -> no change to the sequence length; no second sequence afterwards.
4. Drive gpio_i[2] 0->1->0 with ~5-cycle pulses -> gpio_in[2] follows after SYNC_STAGES; gpio_rise[2] and gpio_fall[2] each high for exactly 1 cycle; no edges on other channels.
5. gpio_i = 3'b111 held through reset -> no gpio_rise pulse during warm-up; gpio_in = 3'b111 after SYNC_STAGES cycles.
6. Toggle uart_rx_o and uart_tx_i -> uart_rx_i follows after 2 cycles, uart_tx_o after 1 cycle; assert reset mid-boot -> esp_en_o = 0 and state returns to RST immediately.
